// File: rtl/mem_bus_if.sv
// Request/response and memory-control signals of the memory bus master.
// The tri-state data bus is kept out of here and is a plain inout port on the master.
interface mem_bus_if #(
   parameter int ADDR_WIDTH = 5,
   parameter int DATA_WIDTH = 8,
   parameter int LEN_WIDTH  = 3
);
   logic                  req_valid;
   logic                  req_ready;
   logic                  req_write;
   logic [ADDR_WIDTH-1:0] req_addr;
   logic [LEN_WIDTH-1:0]  req_len;
   logic [DATA_WIDTH-1:0] wr_data;
   logic                  wr_data_ready;
   logic [DATA_WIDTH-1:0] rd_data;
   logic                  rd_valid;
   logic                  done;
   logic                  mem_read_en;
   logic                  mem_write_en;
   logic [ADDR_WIDTH-1:0] mem_address;

   modport master (
      input  req_valid, req_write, req_addr, req_len, wr_data,
      output req_ready, wr_data_ready, rd_data, rd_valid, done,
             mem_read_en, mem_write_en, mem_address
   );

   modport slave (
      output req_valid, req_write, req_addr, req_len, wr_data,
      input  req_ready, wr_data_ready, rd_data, rd_valid, done,
             mem_read_en, mem_write_en, mem_address
   );
endinterface

// File: rtl/mem_bus_master.sv
// Initiator of single/burst memory reads and writes; owns the shared data bus
// direction and inserts a turnaround gap after every transaction.
module mem_bus_master #(
   parameter int ADDR_WIDTH = 5,
   parameter int DATA_WIDTH = 8,
   parameter int LEN_WIDTH  = 3,
   parameter int TURNAROUND = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   mem_bus_if.master             bus,
   inout  wire  [DATA_WIDTH-1:0] data_bus
);

   localparam int TURN_W = (TURNAROUND > 1) ? $clog2(TURNAROUND) : 1;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_RD      = 3'd1,
      S_RD_TAIL = 3'd2,
      S_WR      = 3'd3,
      S_TURN    = 3'd4
   } state_t;

   state_t                state_q, state_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [LEN_WIDTH-1:0]  cnt_q, cnt_d;
   logic [TURN_W-1:0]     turn_q, turn_d;
   logic                  first_q, first_d;
   logic                  req_ready_q, req_ready_d;
   logic                  read_en_q, read_en_d;
   logic                  write_en_q, write_en_d;
   logic                  wr_ready_q, wr_ready_d;
   logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
   logic                  rd_valid_q, rd_valid_d;
   logic                  done_q, done_d;

   // Bus is driven only during write beats, so it can never collide with memory read data.
   assign data_bus = write_en_q ? bus.wr_data : {DATA_WIDTH{1'bz}};

   assign bus.req_ready     = req_ready_q;
   assign bus.mem_read_en   = read_en_q;
   assign bus.mem_write_en  = write_en_q;
   assign bus.mem_address   = addr_q;
   assign bus.wr_data_ready = wr_ready_q;
   assign bus.rd_data       = rd_data_q;
   assign bus.rd_valid      = rd_valid_q;
   assign bus.done          = done_q;

   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      cnt_d       = cnt_q;
      turn_d      = turn_q;
      first_d     = 1'b0;
      req_ready_d = 1'b0;
      read_en_d   = 1'b0;
      write_en_d  = 1'b0;
      wr_ready_d  = 1'b0;
      rd_data_d   = rd_data_q;
      rd_valid_d  = 1'b0;
      done_d      = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (bus.req_valid) begin
               addr_d = bus.req_addr;
               cnt_d  = bus.req_len;
               if (bus.req_write) begin
                  state_d    = S_WR;
                  write_en_d = 1'b1;
                  wr_ready_d = 1'b1;
               end else begin
                  state_d   = S_RD;
                  read_en_d = 1'b1;
                  first_d   = 1'b1;
               end
            end else begin
               req_ready_d = 1'b1;
            end
         end
         S_RD: begin
            // Memory data lags the address by one cycle, so the first RD cycle carries nothing.
            read_en_d = 1'b1;
            if (!first_q) begin
               rd_valid_d = 1'b1;
               rd_data_d  = data_bus;
            end
            if (cnt_q == '0) begin
               state_d = S_RD_TAIL;
            end else begin
               addr_d = addr_q + 1'b1;
               cnt_d  = cnt_q - 1'b1;
            end
         end
         S_RD_TAIL: begin
            rd_valid_d = 1'b1;
            rd_data_d  = data_bus;
            done_d     = 1'b1;
            state_d    = S_TURN;
            turn_d     = TURN_W'(TURNAROUND - 1);
         end
         S_WR: begin
            if (cnt_q == '0) begin
               state_d = S_TURN;
               done_d  = 1'b1;
               turn_d  = TURN_W'(TURNAROUND - 1);
            end else begin
               write_en_d = 1'b1;
               wr_ready_d = 1'b1;
               addr_d     = addr_q + 1'b1;
               cnt_d      = cnt_q - 1'b1;
            end
         end
         S_TURN: begin
            if (turn_q == '0) begin
               state_d     = S_IDLE;
               req_ready_d = 1'b1;
            end else begin
               turn_d = turn_q - 1'b1;
            end
         end
         default: begin
            state_d     = S_IDLE;
            req_ready_d = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         addr_q      <= '0;
         cnt_q       <= '0;
         turn_q      <= '0;
         first_q     <= 1'b0;
         req_ready_q <= 1'b1;
         read_en_q   <= 1'b0;
         write_en_q  <= 1'b0;
         wr_ready_q  <= 1'b0;
         rd_data_q   <= '0;
         rd_valid_q  <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         cnt_q       <= cnt_d;
         turn_q      <= turn_d;
         first_q     <= first_d;
         req_ready_q <= req_ready_d;
         read_en_q   <= read_en_d;
         write_en_q  <= write_en_d;
         wr_ready_q  <= wr_ready_d;
         rd_data_q   <= rd_data_d;
         rd_valid_q  <= rd_valid_d;
         done_q      <= done_d;
      end
   end

endmodule
